// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit and its instruction buffer.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
  } redirect_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_out_t;

endpackage

// File: rtl/fetch_pc_unit_fetch_buf.sv
// Single-entry instruction buffer holding the word presented to decode.
module fetch_pc_unit_fetch_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic        hold,
  input  logic        flush,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_accept
);

  logic [31:0] ibuf_q, ibuf_d;

  // Handshake: the entry is offered while hold=1 and is taken on hold & out_ready,
  // except when flush squashes it in the same cycle; the word never changes while offered.
  always_comb begin
    ibuf_d     = ibuf_q;
    out_accept = hold & out_ready & ~flush;
    if (load) begin
      ibuf_d = load_instr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ibuf_q <= 32'h0;
    end else begin
      ibuf_q <= ibuf_d;
    end
  end

  assign out_instr = ibuf_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: one outstanding instruction request, single-word buffer, redirect squash.
// Optional misaligned-PC trap to a NOP is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        f_misalign,
`endif
  input  logic        f_ready,
  output logic [1:0]  dbg_state
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  tgt_q, tgt_d;
  redirect_t    redir;
  fetch_out_t   f_out;
  logic         misaligned;
  logic         buf_load;
  logic [31:0]  buf_instr;
  logic         buf_flush;
  logic         buf_accept;
  logic [31:0]  ibuf;

  assign buf_flush = (state_q == HOLD) & redirect_valid;

  always_comb begin
    redir = '{valid: redirect_valid, pc: redirect_pc};
`ifdef FETCH_MISALIGN_CHK_EN
    misaligned = (pc_q[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    buf_load  = 1'b0;
    buf_instr = iresp_data;
    case (state_q)
      FETCH: begin
        if (misaligned) begin
          // No request goes out; decode receives a NOP flagged as misaligned.
          if (redir.valid) begin
            pc_d = redir.pc;
          end else begin
            buf_load  = 1'b1;
            buf_instr = NOP_INSTR;
            state_d   = HOLD;
          end
        end else if (iresp_data_ok) begin
          if (redir.valid) begin
            pc_d = redir.pc;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (redir.valid) begin
          tgt_d   = redir.pc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redir.valid) begin
          tgt_d = redir.pc;
        end
        if (iresp_data_ok) begin
          pc_d    = redir.valid ? redir.pc : tgt_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (buf_flush) begin
          pc_d    = redir.pc;
          state_d = FETCH;
        end else if (buf_accept) begin
          pc_d    = pc_q + 64'd4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if ((state_q == FETCH) && misaligned && !redirect_valid) begin
      misalign_d = 1'b1;
    end else if ((state_q == HOLD) && (state_d != HOLD)) begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign f_misalign = misalign_q;
`endif

  fetch_pc_unit_fetch_buf u_fetch_buf (
    .clk        (clk),
    .resetn     (resetn),
    .load       (buf_load),
    .load_instr (buf_instr),
    .hold       (state_q == HOLD),
    .flush      (buf_flush),
    .out_ready  (f_ready),
    .out_instr  (ibuf),
    .out_accept (buf_accept)
  );

  assign f_out      = '{valid: (state_q == HOLD), pc: pc_q, instr: ibuf};
  assign ireq_valid = resetn & (((state_q == FETCH) & ~misaligned) | (state_q == DROP));
  assign ireq_addr  = pc_q;
  assign f_valid    = f_out.valid;
  assign f_pc       = f_out.pc;
  assign f_instr    = f_out.instr;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // clock/reset block
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  always #5 clk = ~clk;

  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic        f_ready = 1'b0;
  logic        ireq_valid, f_valid;
  logic [63:0] ireq_addr, f_pc;
  logic [31:0] f_instr;
  logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        f_misalign;
`endif

  fetch_pc_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
`ifdef FETCH_MISALIGN_CHK_EN
    .f_misalign     (f_misalign),
`endif
    .f_ready        (f_ready),
    .dbg_state      (dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  // behavioural model: what fetch must look like, independent of any state encoding
  bit          m_buf;       // a word is waiting for decode
  bit          m_stale;     // the request on the bus will be thrown away
  bit          m_mis;
  logic [63:0] m_pc;
  logic [63:0] m_tgt;
  logic [31:0] m_instr;
  int          m_accepts;
  logic [31:0] exp_q[$];

  // bus model
  int bus_lat = 0;          // negative: random 0..3 wait cycles
  bit bus_busy = 0;
  int bus_wait = 0;

  logic        obs_iv, obs_fv, obs_mis;
  logic [63:0] obs_ia, obs_fpc;
  logic [31:0] obs_fi;

  logic [63:0] seq [3] = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f ^ a[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_misaligned();
`ifdef FETCH_MISALIGN_CHK_EN
    return !m_buf && !m_stale && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_buf = 0; m_stale = 0; m_mis = 0;
    m_pc = RST_PC; m_tgt = RST_PC; m_instr = 32'h0; m_accepts = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic rv, input logic [63:0] rpc, input logic ok,
                            input logic [31:0] data, input logic rdy);
    if (m_buf) begin
      if (rv) begin
        m_pc = rpc; m_buf = 0; m_mis = 0;
      end else if (rdy) begin
        exp_q.push_back(m_instr);
        m_accepts++;
        m_pc = m_pc + 64'd4; m_buf = 0; m_mis = 0;
      end
    end else if (m_stale) begin
      if (rv) m_tgt = rpc;
      if (ok) begin
        m_pc = m_tgt; m_stale = 0;
      end
    end else if (model_misaligned()) begin
      if (rv) m_pc = rpc;
      else begin
        m_buf = 1; m_instr = NOP; m_mis = 1;
      end
    end else if (ok) begin
      if (rv) m_pc = rpc;
      else begin
        m_buf = 1; m_instr = data;
      end
    end else if (rv) begin
      m_stale = 1; m_tgt = rpc;
    end
  endtask

  task automatic compare_model();
    chk("ireq_valid", ireq_valid, !m_buf && !model_misaligned());
    chk("ireq_addr", ireq_addr, m_pc);
    chk("f_valid", f_valid, m_buf);
    chk("f_pc", f_pc, m_pc);
    chk("f_instr", f_instr, m_instr);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("f_misalign", f_misalign, m_mis);
`endif
  endtask

  task automatic drive_bus();
    iresp_data_ok = 1'b0;
    iresp_data    = $urandom;
    if (ireq_valid) begin
      if (!bus_busy) begin
        bus_busy = 1;
        bus_wait = (bus_lat < 0) ? int'($urandom_range(0, 3)) : bus_lat;
      end
      if (bus_wait == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem(ireq_addr);
        bus_busy      = 0;
      end else begin
        bus_wait--;
      end
    end
  endtask

  // driver: one clock cycle; outputs sampled at the falling edge, model advanced at the rising edge
  task automatic tick(input logic rv, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    compare_model();
    obs_iv = ireq_valid; obs_ia = ireq_addr; obs_fv = f_valid;
    obs_fpc = f_pc; obs_fi = f_instr;
`ifdef FETCH_MISALIGN_CHK_EN
    obs_mis = f_misalign;
`else
    obs_mis = 1'b0;
`endif
    drive_bus();
    redirect_valid = rv; redirect_pc = rpc; f_ready = rdy;
    @(posedge clk);
    model_step(rv, rpc, iresp_data_ok, iresp_data, rdy);
    if (obs_fv && rdy && !rv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL accept_word: handshake on %h with nothing expected", obs_fi);
      end else begin
        chk("accept_word", obs_fi, exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_ireq_valid", ireq_valid, 64'd0);
    chk("rst_f_valid", f_valid, 64'd0);
    chk("rst_f_pc", f_pc, RST_PC);
    chk("rst_f_instr", f_instr, 64'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_f_misalign", f_misalign, 64'd0);
`endif
    model_reset();
    bus_busy = 0; bus_wait = 0;
    iresp_data_ok = 1'b0; redirect_valid = 1'b0; f_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    logic        rv, rdy;
    logic [63:0] rpc;

    // zero-wait streaming
    do_reset();
    bus_lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 64'h0, 1'b1);
      if (i % 2 == 0) begin
        chk("stream_ireq_valid", obs_iv, 64'd1);
        chk("stream_addr", obs_ia, seq[i/2]);
      end else begin
        chk("stream_f_valid", obs_fv, 64'd1);
        chk("stream_f_instr", obs_fi, mem(seq[i/2]));
      end
    end

    // redirect while a slow request is pending
    do_reset();
    bus_lat = 0;
    tick(1'b0, 64'h0, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    bus_lat = 3;
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 64'h8000_0100, 1'b1);
      chk("drop_addr_stable", obs_ia, 64'h8000_0004);
      chk("drop_no_f_valid", obs_fv, 64'd0);
    end
    bus_lat = 0;
    tick(1'b0, 64'h0, 1'b1);
    chk("drop_next_valid", obs_iv, 64'd1);
    chk("drop_next_addr", obs_ia, 64'h8000_0100);
    tick(1'b0, 64'h0, 1'b1);
    chk("drop_target_pc", obs_fpc, 64'h8000_0100);
    chk("drop_target_instr", obs_fi, mem(64'h8000_0100));

    // redirect coincident with data_ok
    do_reset();
    bus_lat = 0;
    tick(1'b1, 64'h8000_0200, 1'b1);
    chk("coinc_addr", obs_ia, RST_PC);
    tick(1'b0, 64'h0, 1'b1);
    chk("coinc_next_addr", obs_ia, 64'h8000_0200);
    chk("coinc_word_dropped", obs_fv, 64'd0);

    // two redirects while the stale request is outstanding: last one wins
    do_reset();
    bus_lat = 2;
    tick(1'b1, 64'h8000_0300, 1'b0);
    tick(1'b1, 64'h8000_0400, 1'b0);
    tick(1'b0, 64'h0, 1'b0);
    tick(1'b0, 64'h0, 1'b0);
    chk("last_redirect_addr", obs_ia, 64'h8000_0400);

    // decode stalls, then a redirect beats f_ready
    do_reset();
    bus_lat = 0;
    tick(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 64'h0, 1'b0);
      chk("stall_f_valid", obs_fv, 64'd1);
      chk("stall_f_pc", obs_fpc, RST_PC);
      chk("stall_f_instr", obs_fi, mem(RST_PC));
    end
    tick(1'b1, 64'h8000_0500, 1'b1);
    chk("stall_no_accept", 64'(m_accepts), 64'd0);
    tick(1'b0, 64'h0, 1'b1);
    chk("stall_redirect_addr", obs_ia, 64'h8000_0500);

    // sequential PC wraps at 64 bits
    do_reset();
    bus_lat = 0;
    tick(1'b1, 64'hffff_ffff_ffff_fffc, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    tick(1'b0, 64'h0, 1'b1);
    chk("wrap_addr", obs_ia, 64'h0);

    // asynchronous reset while dropping a stale request
    do_reset();
    bus_lat = 3;
    tick(1'b0, 64'h0, 1'b0);
    tick(1'b1, 64'h8000_0600, 1'b0);
    do_reset();
    bus_lat = 0;
    tick(1'b0, 64'h0, 1'b0);
    chk("post_reset_addr", obs_ia, RST_PC);
    chk("post_reset_valid", obs_iv, 64'd1);

    // misaligned redirect target
    do_reset();
    bus_lat = 0;
    tick(1'b1, 64'h8000_0002, 1'b0);
    tick(1'b0, 64'h0, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_no_request", obs_iv, 64'd0);
    tick(1'b0, 64'h0, 1'b0);
    chk("mis_f_valid", obs_fv, 64'd1);
    chk("mis_flag", obs_mis, 64'd1);
    chk("mis_nop", obs_fi, 64'(NOP));
`else
    chk("mis_request_issued", obs_iv, 64'd1);
    chk("mis_request_addr", obs_ia, 64'h8000_0002);
    chk("mis_flag_absent", obs_mis, 64'd0);
`endif

    // randomized traffic
    do_reset();
    bus_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rv  = ($urandom_range(0, 7) == 0);
      rpc = RST_PC + 64'($urandom_range(0, 255)) * 64'd4
            + (($urandom_range(0, 15) == 0) ? 64'd2 : 64'd0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(rv, rpc, rdy);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
